// File: rtl/result_reader_if.sv
// Bus bundle for the result reader: the SRAM read port and the byte stream.
// master = the reader (drives SRAM control and the stream), slave = SRAM + sink.
interface result_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // SRAM side
  logic              cs_n;
  logic              we_n;
  logic [ADDR_W-1:0] address;
  logic              ry;
  logic [DATA_W-1:0] read_data;
  // Byte stream side
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output cs_n, we_n, address, out_data, out_valid, out_last,
    input  ry, read_data, out_ready
  );

  modport slave (
    input  cs_n, we_n, address, out_data, out_valid, out_last,
    output ry, read_data, out_ready
  );
endinterface

// File: rtl/result_reader.sv
// Result SRAM read-back: fetches NUM_WORDS consecutive words from base_addr
// and streams each as four bytes, MSB first, on a valid/ready interface.
// Any SRAM that stays silent for TIMEOUT cycles aborts the burst with err set.
module result_reader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  result_reader_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        byte_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] shreg;
  logic              err_q;
  logic              cs_n, out_valid, out_last;
  logic              last_word, byte_taken;

  assign last_word  = (idx == LAST_IDX);
  assign byte_taken = (state == S_SEND) && bus.out_ready;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state and Moore outputs of the burst controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n   = state;
    cs_n      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_REQ;
      S_REQ: begin
        cs_n    = 1'b0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        cs_n = 1'b0;
        if (bus.ry)                   state_n = S_SEND;
        else if (tmo_cnt == TMO_LAST) state_n = S_DONE;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = last_word && (byte_cnt == 2'd3);
        if (bus.out_ready && byte_cnt == 2'd3)
          state_n = last_word ? S_DONE : S_REQ;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: burst bookkeeping, timeout counter and byte shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base     <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      shreg    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base  <= base_addr;
          idx   <= '0;
          err_q <= 1'b0;
        end
        S_REQ: tmo_cnt <= '0;
        S_WAIT: begin
          if (bus.ry) begin
            shreg    <= bus.read_data;
            byte_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_SEND: if (byte_taken) begin
          shreg    <= {shreg[DATA_W-9:0], 8'h00};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3 && !last_word) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address wraps modulo 2**ADDR_W through natural truncation of the sum.
  assign bus.cs_n      = cs_n;
  assign bus.we_n      = 1'b1;
  assign bus.address   = base + idx;
  assign bus.out_data  = shreg[DATA_W-1 -: 8];
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: SRAM model with programmable ready
// latency, byte-stream monitor, and a burst model computed from memory contents.
module tb_result_reader;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 2;
  localparam int TIMEOUT   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done, err;

  result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  result_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model: ry rises ry_lat cycles after cs_n falls
  logic [31:0] mem [256];
  int          ry_lat  = 1;
  int          req_age = 0;

  always @(posedge clk) req_age <= (bus.cs_n !== 1'b0) ? 0 : req_age + 1;
  assign bus.ry        = (bus.cs_n === 1'b0) && (req_age >= ry_lat);
  assign bus.read_data = bus.ry ? mem[bus.address] : 32'hBAD0_BAD0;

  // ---------------- Monitor (sampled on the falling edge)
  logic [7:0] got_bytes[$];
  bit         got_last[$];
  logic [7:0] got_addrs[$];
  int done_cnt = 0, cs_low_cnt = 0, stall_err = 0, addr_err = 0, we_err = 0;
  logic       prev_stall = 1'b0, prev_last = 1'b0, prev_cs_n = 1'b1;
  logic [7:0] prev_data = '0, prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        got_bytes.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
      end
      if (prev_stall && !(bus.out_valid && bus.out_data == prev_data && bus.out_last == prev_last))
        stall_err <= stall_err + 1;
      if (!bus.cs_n && prev_cs_n) got_addrs.push_back(bus.address);
      if (!bus.cs_n && !prev_cs_n && bus.address != prev_addr) addr_err <= addr_err + 1;
      if (!bus.cs_n) cs_low_cnt <= cs_low_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (bus.we_n !== 1'b1) we_err <= we_err + 1;
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
      prev_last  <= bus.out_last;
      prev_cs_n  <= bus.cs_n;
      prev_addr  <= bus.address;
    end else begin
      prev_stall <= 1'b0;
      prev_cs_n  <= 1'b1;
    end
  end

  // ---------------- Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 toggle, 2 random, 3 held low
  int ready_mode = 0;
  task automatic drive_ready();
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  // Burst model: expected addresses and byte stream from memory contents.
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_addrs[$];
  int byte0, addr0, done0, cs0, stall0, aerr0;

  task automatic begin_burst(input logic [7:0] b);
    logic [7:0]  a;
    logic [31:0] word;
    exp_bytes.delete();
    exp_addrs.delete();
    for (int w = 0; w < NUM_WORDS; w++) begin
      a = b + 8'(w);
      exp_addrs.push_back(a);
      word = mem[a];
      for (int k = 0; k < 4; k++) exp_bytes.push_back(word[31 - 8*k -: 8]);
    end
    byte0 = got_bytes.size(); addr0 = got_addrs.size(); done0 = done_cnt;
    cs0 = cs_low_cnt; stall0 = stall_err; aerr0 = addr_err;
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == done0 && n < 2000) begin
      drive_ready();
      tick();
      n++;
    end
    check({tag, " done_seen"}, 32'(done_cnt != done0), 32'd1);
    tick();
    tick();
  endtask

  task automatic compare_burst(input string tag);
    logic [7:0] g;
    bit         l;
    check({tag, " nbytes"}, 32'(got_bytes.size() - byte0), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++) begin
      g = (byte0 + i < got_bytes.size()) ? got_bytes[byte0 + i] : 8'hxx;
      l = (byte0 + i < got_last.size())  ? got_last[byte0 + i]  : 1'b0;
      check($sformatf("%s byte%0d", tag, i), 32'(g), 32'(exp_bytes[i]));
      check($sformatf("%s last%0d", tag, i), 32'(l), 32'(i == exp_bytes.size() - 1));
    end
    check({tag, " naddr"}, 32'(got_addrs.size() - addr0), 32'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size(); i++) begin
      g = (addr0 + i < got_addrs.size()) ? got_addrs[addr0 + i] : 8'hxx;
      check($sformatf("%s addr%0d", tag, i), 32'(g), 32'(exp_addrs[i]));
    end
    check({tag, " done_pulses"}, 32'(done_cnt - done0), 32'd1);
    check({tag, " stall_stable"}, 32'(stall_err - stall0), 32'd0);
    check({tag, " addr_held"}, 32'(addr_err - aerr0), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " err_after"}, 32'(err), 32'd0);
  endtask

  // Watchdog: stop hard if the flow ever wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    bus.out_ready = 1'b1;

    // 1. Reset held with start asserted.
    start = 1'b1; base_addr = 8'h77;
    repeat (3) tick();
    check("rst cs_n", 32'(bus.cs_n), 32'd1);
    check("rst we_n", 32'(bus.we_n), 32'd1);
    check("rst address", 32'(bus.address), 32'd0);
    check("rst out_data", 32'(bus.out_data), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_last", 32'(bus.out_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    start = 1'b0;
    rst = 1'b1;
    tick();

    // 2. Single burst, first-byte latency (start driven -> 3 edges -> out_valid).
    mem[8'h10] = 32'hA1B2_C3D4;
    mem[8'h11] = 32'h0102_0304;
    ry_lat = 1; ready_mode = 0; bus.out_ready = 1'b1;
    begin_burst(8'h10);
    n = 1;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("single latency", 32'(n), 32'd3);
    wait_done("single");
    compare_burst("single");

    // 3. Backpressure with toggling ready.
    mem[8'h20] = 32'hDEAD_BEEF;
    ready_mode = 1;
    begin_burst(8'h20);
    wait_done("bp");
    compare_burst("bp");

    // 4. Address wrap.
    ready_mode = 0;
    begin_burst(8'hFE);
    wait_done("wrapFE");
    compare_burst("wrapFE");
    begin_burst(8'hFF);
    wait_done("wrapFF");
    compare_burst("wrapFF");

    // 5. Timeout: REQ cycle plus TIMEOUT WAIT cycles with cs_n low, then err.
    ry_lat = 1000;
    begin_burst(8'h30);
    wait_done("tmo");
    check("tmo cs_low_cycles", 32'(cs_low_cnt - cs0), 32'(TIMEOUT + 1));
    check("tmo err", 32'(err), 32'd1);
    check("tmo no_bytes", 32'(got_bytes.size() - byte0), 32'd0);
    check("tmo done_pulses", 32'(done_cnt - done0), 32'd1);
    ry_lat = 1;
    begin_burst(8'h31);
    check("tmo err_cleared", 32'(err), 32'd0);
    wait_done("after_tmo");
    compare_burst("after_tmo");

    // 6a. Start during SEND is ignored.
    ry_lat = 2; ready_mode = 3; bus.out_ready = 1'b0;
    begin_burst(8'h40);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("ign reached_send", 32'(bus.out_valid), 32'd1);
    base_addr = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ready_mode = 0;
    wait_done("ignore");
    compare_burst("ignore");

    // 6b. Reset while waiting on the SRAM.
    ry_lat = 1000;
    begin_burst(8'h50);
    repeat (3) tick();
    check("abort cs_low_before", 32'(bus.cs_n), 32'd0);
    rst = 1'b0;
    tick();
    check("abort cs_n", 32'(bus.cs_n), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    done0 = done_cnt;
    repeat (5) tick();
    check("abort no_done", 32'(done_cnt - done0), 32'd0);
    check("abort err", 32'(err), 32'd0);

    // Randomized bursts against the model.
    for (int r = 0; r < 8; r++) begin
      ry_lat = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 2);
      for (int i = 0; i < 256; i += 7) mem[i] = $urandom;
      begin_burst(8'($urandom));
      wait_done($sformatf("rand%0d", r));
      compare_burst($sformatf("rand%0d", r));
    end

    check("we_n never low", 32'(we_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
